// File: rtl/teclado_pkg.sv
// Shared definitions for the matrix-keypad scanner: FSM states, the key-code
// width helper and the 4x4 legend used by downstream input handling.
package teclado_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HOLD      = 2'd2,
        DEB_REL   = 2'd3
    } estado_t;

    // Width of a raw key code for an n_filas x n_cols keypad (at least 1 bit).
    function automatic int key_width(input int n_filas, input int n_cols);
        int n;
        n = n_filas * n_cols;
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Raw code (fila*4 + col) to printed symbol on a standard 4x4 keypad.
    localparam logic [7:0] LEYENDA_4X4 [16] = '{
        "1", "2", "3", "A",
        "4", "5", "6", "B",
        "7", "8", "9", "C",
        "*", "0", "#", "D"
    };

    // Symbol lookup for a 4x4 raw code.
    function automatic logic [7:0] leyenda(input logic [3:0] code);
        return LEYENDA_4X4[code];
    endfunction

endpackage

// File: rtl/fifo_teclas.sv
// Generic synchronous FIFO. A push while full is accepted only if a pop
// happens in the same cycle; a pop while empty is ignored. The head entry is
// shown combinationally from the registered read pointer (0 when empty).
module fifo_teclas #(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/teclado_escaner_fifo.sv
// Matrix-keypad scanner: walks a single low column, synchronises the
// active-low rows, debounces press and release, and queues one code per
// press into a FIFO read through a valid/ready handshake.
//
// Handshake: an entry leaves the FIFO on a rising clk edge where
// tecla_valid && tecla_ready; tecla_code is the head entry while tecla_valid.
module teclado_escaner_fifo
    import teclado_pkg::*;
#(
    parameter int N_FILAS    = 4,
    parameter int N_COLS     = 4,
    parameter int N_DEB      = 18,
    parameter int SCAN_DIV   = 1024,
    parameter int FIFO_DEPTH = 8,
    localparam int KEY_W     = key_width(N_FILAS, N_COLS),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_FILAS-1:0] filas,
    output logic [N_COLS-1:0]  columnas,
    output logic [KEY_W-1:0]   tecla_code,
    output logic               tecla_valid,
    input  logic               tecla_ready,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               tecla_presionada,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int ROW_W = (N_FILAS > 1) ? $clog2(N_FILAS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [N_DEB-1:0] DEB_MAX  = {N_DEB{1'b1}};

    // FSM state is kept as a named signal so checkers can bind to it.
    estado_t            estado, estado_n;
    logic [N_FILAS-1:0] filas_m, filas_s;
    logic [N_FILAS-1:0] patron, patron_n;
    logic [COL_W-1:0]   col_idx, col_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [N_DEB-1:0]   deb_cnt, deb_n;
    logic [ROW_W-1:0]   fila_idx;
    logic [KEY_W-1:0]   codigo;
    logic               push;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;

    // Two-flop synchroniser for the asynchronous row inputs (idle = all ones).
    always_ff @(posedge clk) begin
        if (rst) begin
            filas_m <= '1;
            filas_s <= '1;
        end else begin
            filas_m <= filas;
            filas_s <= filas_m;
        end
    end

    // State, column, divider, debounce counter and latched row pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= SCAN;
            col_idx <= '0;
            div_cnt <= '0;
            deb_cnt <= '0;
            patron  <= '1;
        end else begin
            estado  <= estado_n;
            col_idx <= col_n;
            div_cnt <= div_n;
            deb_cnt <= deb_n;
            patron  <= patron_n;
        end
    end

    // Next-state logic: scan, debounce press, hold, debounce release.
    always_comb begin
        estado_n = estado;
        col_n    = col_idx;
        div_n    = div_cnt;
        deb_n    = deb_cnt;
        patron_n = patron;
        push     = 1'b0;
        case (estado)
            SCAN: begin
                if (filas_s != '1) begin
                    patron_n = filas_s;
                    deb_n    = '0;
                    estado_n = DEB_PRESS;
                end else if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    col_n = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            DEB_PRESS: begin
                if (filas_s == '1) begin
                    estado_n = SCAN;
                end else if (filas_s != patron) begin
                    patron_n = filas_s;
                    deb_n    = '0;
                end else if (deb_cnt == DEB_MAX) begin
                    push     = 1'b1;
                    deb_n    = '0;
                    estado_n = HOLD;
                end else begin
                    deb_n = deb_cnt + N_DEB'(1);
                end
            end
            HOLD: begin
                if (filas_s == '1) begin
                    deb_n    = '0;
                    estado_n = DEB_REL;
                end
            end
            DEB_REL: begin
                if (filas_s != '1) begin
                    estado_n = HOLD;
                end else if (deb_cnt == DEB_MAX) begin
                    estado_n = SCAN;
                    div_n    = '0;
                    col_n    = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
                end else begin
                    deb_n = deb_cnt + N_DEB'(1);
                end
            end
            default: estado_n = SCAN;
        endcase
    end

    // Lowest low row of the latched pattern wins when several rows are low.
    always_comb begin
        fila_idx = '0;
        for (int i = N_FILAS - 1; i >= 0; i--) begin
            if (!patron[i]) begin
                fila_idx = ROW_W'(i);
            end
        end
    end

    assign codigo = KEY_W'(int'(fila_idx) * N_COLS + int'(col_idx));

    // Exactly one column driven low.
    always_comb begin
        columnas          = '1;
        columnas[col_idx] = 1'b0;
    end

    assign tecla_presionada = (estado == HOLD);
    assign tecla_valid      = !fifo_empty;

    // A confirmed key is lost only if the FIFO is full and nothing leaves it.
    assign drop = push && fifo_full && !tecla_ready;

    // Sticky overflow flag; a new drop takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    fifo_teclas #(
        .W     (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (tecla_ready),
        .din   (codigo),
        .dout  (tecla_code),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
